serial_tx: RTL and testbench



---
 rtl/serial_pkg.sv | 22 ++
 rtl/serial_baud_gen.sv | 31 +++
 rtl/serial_tx.sv | 137 +++++++++++++
 tb/tb_serial_tx.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// serial_pkg: shared types and helpers for the serial transmitter.
// Holds the FSM state enum, bit-time helper and idle line level.
package serial_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam logic LINE_IDLE = 1'b1;

  function automatic int clks_per_bit(
    input int freq,
    input int baud
  );
    return freq / baud;
  endfunction

endpackage

// File: rtl/serial_baud_gen.sv
// serial_baud_gen: bit-time counter, pulses o_bit_done at terminal count.
// Ports: clk, reset, i_en (frame active), i_clr (accept), o_bit_done.
module serial_baud_gen #(
  parameter int CPB = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  input  logic i_clr,
  output logic o_bit_done
);

  localparam int CW = $clog2(CPB);

  logic [CW-1:0] r_cnt;
  logic          w_term;

  assign w_term     = (r_cnt == CW'(CPB - 1));
  assign o_bit_done = i_en & w_term;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr || !i_en || w_term) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/serial_tx.sv
// serial_tx: async serial transmitter, start + LSB-first data + stop.
// Ports: clk, reset, tx_valid/tx_data in; tx_ready, tx, busy out.
// Optional parity bit enabled by SERIAL_PARITY_EN (PARITY_ODD inverts).
module serial_tx
  import serial_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200,
  parameter int DATA_W   = 8
`ifdef SERIAL_PARITY_EN
  ,
  parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              tx,
  output logic              busy
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int IW = $clog2(DATA_W);

  if (CLKS_PER_BIT < 2) begin : g_cpb_chk
    $error("serial_tx: CLK_FREQ/BAUD must be at least 2");
  end

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shift_nxt;
  logic [IW-1:0]     r_idx;
  logic [IW-1:0]     w_idx_nxt;
  logic              r_tx;
  logic              w_tx_nxt;
  logic              w_accept;
  logic              w_bit_done;
  logic              w_active;

  assign w_active = (r_state != S_IDLE);
  assign w_accept = tx_valid & ~w_active;
  assign tx_ready = ~w_active;
  assign busy     = w_active;
  assign tx       = r_tx;

  serial_baud_gen #(
    .CPB(CLKS_PER_BIT)
  ) u_baud (
    .clk       (clk),
    .reset     (reset),
    .i_en      (w_active),
    .i_clr     (w_accept),
    .o_bit_done(w_bit_done)
  );

`ifdef SERIAL_PARITY_EN
  logic r_par;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_par <= 1'b0;
    end else if (w_accept) begin
      r_par <= (^tx_data) ^ PARITY_ODD;
    end
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_idx_nxt   = r_idx;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_START;
          w_shift_nxt = tx_data;
          w_idx_nxt   = '0;
        end
      end
      S_START: begin
        if (w_bit_done) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        if (w_bit_done) begin
          w_shift_nxt = r_shift >> 1;
          if (r_idx == IW'(DATA_W - 1)) begin
            w_idx_nxt = '0;
`ifdef SERIAL_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (w_bit_done) w_state_nxt = S_STOP;
      end
      S_STOP: begin
        if (w_bit_done) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // tx is registered from the upcoming state, so the line
    // changes on the same edge the FSM does.
    w_tx_nxt = LINE_IDLE;
    case (w_state_nxt)
      S_START: w_tx_nxt = 1'b0;
      S_DATA:  w_tx_nxt = w_shift_nxt[0];
`ifdef SERIAL_PARITY_EN
      S_PARITY: w_tx_nxt = r_par;
`endif
      default: w_tx_nxt = LINE_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_idx   <= '0;
      r_tx    <= LINE_IDLE;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_idx   <= w_idx_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: directed vectors for serial_tx at 4 clocks per bit,
// plus one bit-width measurement at the default 50 MHz / 115200.
module tb_serial_tx;

  localparam int CPB = 4;
`ifdef SERIAL_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready;
  logic       tx;
  logic       busy;

  logic       d_valid = 1'b0;
  logic [7:0] d_data = 8'h00;
  logic       d_ready;
  logic       d_tx;
  logic       d_busy;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  serial_tx #(
    .CLK_FREQ(1000),
    .BAUD    (250),
    .DATA_W  (8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .tx_valid(tx_valid),
    .tx_data (tx_data),
    .tx_ready(tx_ready),
    .tx      (tx),
    .busy    (busy)
  );

  serial_tx dut_def (
    .clk     (clk),
    .reset   (reset),
    .tx_valid(d_valid),
    .tx_data (d_data),
    .tx_ready(d_ready),
    .tx      (d_tx),
    .busy    (d_busy)
  );

  // frame bits in line order: bit 0 is the start bit
  typedef struct {
    logic [7:0]  data;
    logic [10:0] frame;
    int          inject;
  } vec_t;

  vec_t vt[4];

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t",
                  name, act, exp, $time);
  endtask

  task automatic idle_chk(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_tx", tx, 1);
      chk("idle_ready", tx_ready, 1);
      chk("idle_busy", busy, 0);
    end
  endtask

  task automatic accept(input logic [7:0] d, input bit hold);
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = d;
    chk("ready_pre", tx_ready, 1);
    @(posedge clk);
    #1;
    if (!hold) tx_valid = 1'b0;
    tx_data = ~d;
  endtask

  task automatic run_frame(input logic [10:0] f, input int inj);
    for (int c = 0; c < NB * CPB; c++) begin
      @(negedge clk);
      if (inj >= 0 && c == inj + 1) tx_valid = 1'b0;
      chk("frame_tx", tx, f[c / CPB]);
      chk("frame_ready", tx_ready, 0);
      chk("frame_busy", busy, 1);
      if (inj >= 0 && c == inj) begin
        tx_valid = 1'b1;
        tx_data  = 8'h00;
      end
    end
  endtask

  task automatic end_chk();
    @(negedge clk);
    chk("end_ready", tx_ready, 1);
    chk("end_busy", busy, 0);
    chk("end_tx", tx, 1);
  endtask

  task automatic reset_mid(input logic [7:0] d, input int at,
                           input logic exp_pre);
    accept(d, 1'b0);
    for (int c = 0; c < at; c++) @(negedge clk);
    chk("rst_pre_tx", tx, exp_pre);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_async_tx", tx, 1);
    chk("rst_async_ready", tx_ready, 1);
    chk("rst_async_busy", busy, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    idle_chk(50);
  endtask

  initial begin
`ifdef SERIAL_PARITY_EN
    vt[0] = '{8'h55, 11'b10010101010, -1};
    vt[1] = '{8'h3C, 11'b10001111000, -1};
    vt[2] = '{8'h07, 11'b11000001110, -1};
    vt[3] = '{8'h55, 11'b10010101010, 10};
`else
    vt[0] = '{8'h55, 11'b01010101010, -1};
    vt[1] = '{8'h3C, 11'b01001111000, -1};
    vt[2] = '{8'h07, 11'b01000001110, -1};
    vt[3] = '{8'h55, 11'b01010101010, 10};
`endif

    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_ready", tx_ready, 1);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    idle_chk(20);

    for (int i = 0; i < 4; i++) begin
      accept(vt[i].data, 1'b0);
      run_frame(vt[i].frame, vt[i].inject);
      end_chk();
      idle_chk(5);
    end

    // back-to-back with tx_valid held: one idle cycle between frames
    accept(8'hA5, 1'b1);
    tx_data = 8'h3C;
`ifdef SERIAL_PARITY_EN
    run_frame(11'b10101001010, -1);
`else
    run_frame(11'b01101001010, -1);
`endif
    @(negedge clk);
    chk("b2b_gap_tx", tx, 1);
    chk("b2b_gap_ready", tx_ready, 1);
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    tx_data  = 8'hFF;
`ifdef SERIAL_PARITY_EN
    run_frame(11'b10001111000, -1);
`else
    run_frame(11'b01001111000, -1);
`endif
    end_chk();
    idle_chk(5);

    reset_mid(8'hFF, 13, 1'b1);
    reset_mid(8'h00, 2, 1'b0);

    // default parameters: alternating bits, each must be 434 clocks
    @(negedge clk);
    d_valid = 1'b1;
    d_data  = 8'h55;
    chk("def_ready_pre", d_ready, 1);
    @(posedge clk);
    #1;
    d_valid = 1'b0;
    @(negedge clk);
    for (int r = 0; r < 8; r++) begin
      int   n;
      logic lvl;
      lvl = r[0];
      n = 0;
      chk("def_level", d_tx, lvl);
      while (d_tx == lvl && n < 2000) begin
        n++;
        @(negedge clk);
      end
      chk("def_bit_len", n, 434);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
